alu_share_ctrl: RTL and testbench

- Sequencing controller that lets two requesters share one registered 32-bit ALU (f codes 010 add, 110 sub, 011 and, 100 or, 111 slt).
- Arbitrates round-robin between the two requesters, drives the ALU operand/function inputs from registers, and waits the ALU's clocked latency.
- Captures the result and returns it on a per-requester valid/ready response channel.
- Sits between the datapath issue logic and the alu instance.

---
 rtl/alu_share_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: lets two requesters share one registered 32-bit ALU.
// It picks one request round-robin, launches the operands into registers
// that feed the ALU, waits out the ALU latency, captures the result and
// hands it back on the owner's valid/ready response channel. Only one
// operation is in flight at a time.
module alu_share_ctrl #(
   parameter int ALU_LAT = 1,   // extra cycles after launch before alu_y is sampled (0..7)
   parameter int CNT_W   = 16   // width of the completed-operation counter
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [31:0]       req0_a,
   input  logic [31:0]       req1_a,
   input  logic [31:0]       req0_b,
   input  logic [31:0]       req1_b,
   input  logic [2:0]        req0_f,
   input  logic [2:0]        req1_f,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   input  logic              rsp0_ready,
   input  logic              rsp1_ready,
   output logic [31:0]       rsp_y,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [2:0]        alu_f,
   input  logic [31:0]       alu_y,
   output logic [CNT_W-1:0]  ops_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

   state_t               state_q, state_d;
   logic                 last_grant_q, last_grant_d;
   logic                 owner_q, owner_d;
   logic [2:0]           cnt_q, cnt_d;
   logic signed [31:0]   alu_a_q, alu_a_d;
   logic signed [31:0]   alu_b_q, alu_b_d;
   logic [2:0]           alu_f_q, alu_f_d;
   logic signed [31:0]   rsp_y_q, rsp_y_d;
   logic                 rsp_zero_q, rsp_zero_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]     ops_q, ops_d;

   logic                 gnt_vld;
   logic                 gnt;
   logic signed [31:0]   sel_a;
   logic signed [31:0]   sel_b;
   logic [2:0]           sel_f;
   logic                 owner_rdy;

   // Codes the ALU implements; everything else is answered locally as an error.
   function automatic logic f_legal(input logic [2:0] f);
      case (f)
         3'b010, 3'b110, 3'b011, 3'b100, 3'b111: f_legal = 1'b1;
         default:                                f_legal = 1'b0;
      endcase
   endfunction

   // Round-robin pick: a lone valid wins, a tie goes to whoever was not served last.
   always_comb begin
      gnt_vld   = req0_valid | req1_valid;
      gnt       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
      sel_a     = gnt ? req1_a : req0_a;
      sel_b     = gnt ? req1_b : req0_b;
      sel_f     = gnt ? req1_f : req0_f;
      owner_rdy = owner_q ? rsp1_ready : rsp0_ready;
   end

   // Next-state logic for the accept / wait / respond sequence.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_f_d      = alu_f_q;
      rsp_y_d      = rsp_y_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      ops_d        = ops_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               // Operands are launched even for an illegal code; the ALU result is simply never sampled.
               alu_a_d      = sel_a;
               alu_b_d      = sel_b;
               alu_f_d      = sel_f;
               owner_d      = gnt;
               last_grant_d = gnt;
               if (f_legal(sel_f)) begin
                  state_d = S_WAIT;
                  cnt_d   = LAT_INIT;
               end else begin
                  state_d    = S_RESP;
                  rsp_y_d    = '0;
                  rsp_zero_d = 1'b1;
                  rsp_err_d  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               rsp_y_d    = alu_y;
               rsp_zero_d = (alu_y == 32'd0);
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            // Only the owner's ready can retire the response.
            if (owner_rdy) begin
               if (ops_q != '1) begin
                  ops_d = ops_q + 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         cnt_q        <= 3'd0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_f_q      <= 3'd0;
         rsp_y_q      <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         ops_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_f_q      <= alu_f_d;
         rsp_y_q      <= rsp_y_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         ops_q        <= ops_d;
      end
   end

   assign req0_ready = (state_q == S_IDLE) && gnt_vld && !gnt;
   assign req1_ready = (state_q == S_IDLE) && gnt_vld && gnt;
   assign rsp0_valid = (state_q == S_RESP) && !owner_q;
   assign rsp1_valid = (state_q == S_RESP) && owner_q;
   assign rsp_y      = rsp_y_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_f      = alu_f_q;
   assign ops_done   = ops_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (default latency/counter and
// ALU_LAT=3 / CNT_W=2), each driving a behavioural registered ALU.
module tb_alu_share_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        rv   [2][2];
   logic        rr   [2][2];
   logic [31:0] ra   [2][2];
   logic [31:0] rb   [2][2];
   logic [2:0]  rf   [2][2];
   logic        sv   [2][2];
   logic        srdy [2][2];
   logic [31:0] ry   [2];
   logic        rz   [2];
   logic        re   [2];
   logic [31:0] aa   [2];
   logic [31:0] ab   [2];
   logic [2:0]  af   [2];
   logic [31:0] ay   [2];
   logic [15:0] od0;
   logic [1:0]  od1;

   typedef struct {
      int          d;
      int          r;
      logic [31:0] y;
      logic        z;
      logic        e;
   } exp_t;

   exp_t q[$];
   int   ntests = 0;
   int   nfail  = 0;
   int   exp_ops [2];

   always #5 clk = ~clk;

   alu_share_ctrl u_dut0 (
      .clk(clk), .reset(reset),
      .req0_valid(rv[0][0]), .req1_valid(rv[0][1]),
      .req0_ready(rr[0][0]), .req1_ready(rr[0][1]),
      .req0_a(ra[0][0]), .req1_a(ra[0][1]),
      .req0_b(rb[0][0]), .req1_b(rb[0][1]),
      .req0_f(rf[0][0]), .req1_f(rf[0][1]),
      .rsp0_valid(sv[0][0]), .rsp1_valid(sv[0][1]),
      .rsp0_ready(srdy[0][0]), .rsp1_ready(srdy[0][1]),
      .rsp_y(ry[0]), .rsp_zero(rz[0]), .rsp_err(re[0]),
      .alu_a(aa[0]), .alu_b(ab[0]), .alu_f(af[0]), .alu_y(ay[0]),
      .ops_done(od0)
   );

   alu_share_ctrl #(.ALU_LAT(3), .CNT_W(2)) u_dut1 (
      .clk(clk), .reset(reset),
      .req0_valid(rv[1][0]), .req1_valid(rv[1][1]),
      .req0_ready(rr[1][0]), .req1_ready(rr[1][1]),
      .req0_a(ra[1][0]), .req1_a(ra[1][1]),
      .req0_b(rb[1][0]), .req1_b(rb[1][1]),
      .req0_f(rf[1][0]), .req1_f(rf[1][1]),
      .rsp0_valid(sv[1][0]), .rsp1_valid(sv[1][1]),
      .rsp0_ready(srdy[1][0]), .rsp1_ready(srdy[1][1]),
      .rsp_y(ry[1]), .rsp_zero(rz[1]), .rsp_err(re[1]),
      .alu_a(aa[1]), .alu_b(ab[1]), .alu_f(af[1]), .alu_y(ay[1]),
      .ops_done(od1)
   );

   // Reference ALU function.
   function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      case (f)
         3'b010:  ref_y = a + b;
         3'b110:  ref_y = a - b;
         3'b011:  ref_y = a & b;
         3'b100:  ref_y = a | b;
         3'b111:  ref_y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: ref_y = 32'd0;
      endcase
   endfunction

   function automatic logic legal(input logic [2:0] f);
      legal = (f == 3'b010) || (f == 3'b110) || (f == 3'b011) || (f == 3'b100) || (f == 3'b111);
   endfunction

   function automatic logic [31:0] get_od(input int d);
      get_od = (d == 0) ? 32'(od0) : 32'(od1);
   endfunction

   function automatic int ops_max(input int d);
      ops_max = (d == 0) ? 65535 : 3;
   endfunction

   // Behavioural registered ALU, one per instance.
   always @(posedge clk) begin
      ay[0] <= ref_y(aa[0], ab[0], af[0]);
      ay[1] <= ref_y(aa[1], ab[1], af[1]);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input int d, input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      rv[d][r] = 1'b1;
      ra[d][r] = a;
      rb[d][r] = b;
      rf[d][r] = f;
   endtask

   // Wait for the grant of an already-presented request, record the expected
   // response, and check the operands launched on the accepting edge.
   task automatic issue(input int d, input int r, output int waited);
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f;
      logic [31:0] y;
      exp_t        e;
      int          n;
      a = ra[d][r];
      b = rb[d][r];
      f = rf[d][r];
      n = 0;
      #4;
      while (!rr[d][r] && n < 30) begin
         tick();
         #4;
         n++;
      end
      waited = n;
      check("req_ready", 32'(rr[d][r]), 32'd1);
      check("other_ready_low", 32'(rr[d][1-r]), 32'd0);
      y   = ref_y(a, b, f);
      e.d = d;
      e.r = r;
      e.y = y;
      e.z = legal(f) ? (y == 32'd0) : 1'b1;
      e.e = !legal(f);
      q.push_back(e);
      tick();
      rv[d][r] = 1'b0;
      check("alu_a", aa[d], a);
      check("alu_b", ab[d], b);
      check("alu_f", 32'(af[d]), 32'(f));
   endtask

   // Wait for the response, compare with the scoreboard, optionally hold
   // backpressure, then complete the handshake.
   task automatic collect(input int d, input int r, input int exp_edges, input int hold);
      exp_t        e;
      logic [31:0] snap;
      int          n;
      n = 0;
      srdy[d][r] = 1'b0;
      while (!sv[d][r] && n < 20) begin
         check("no_grant_in_flight", 32'(rr[d][0] | rr[d][1]), 32'd0);
         tick();
         n++;
      end
      check("latency_edges", 32'(n), 32'(exp_edges));
      check("rsp_valid", 32'(sv[d][r]), 32'd1);
      check("other_rsp_valid_low", 32'(sv[d][1-r]), 32'd0);
      if (q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         check("rsp_owner", 32'(r), 32'(e.r));
         check("rsp_y", ry[d], e.y);
         check("rsp_zero", 32'(rz[d]), 32'(e.z));
         check("rsp_err", 32'(re[d]), 32'(e.e));
      end
      snap = ry[d];
      srdy[d][1-r] = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", 32'(sv[d][r]), 32'd1);
         check("hold_y", ry[d], snap);
         check("hold_no_grant", 32'(rr[d][0] | rr[d][1]), 32'd0);
      end
      srdy[d][1-r] = 1'b0;
      srdy[d][r]   = 1'b1;
      tick();
      srdy[d][r] = 1'b0;
      if (exp_ops[d] < ops_max(d)) exp_ops[d]++;
      check("rsp_valid_drop", 32'(sv[d][r]), 32'd0);
      check("ops_done", get_od(d), 32'(exp_ops[d]));
   endtask

   task automatic check_cleared(input int d);
      check("clr_alu_a", aa[d], 32'd0);
      check("clr_alu_b", ab[d], 32'd0);
      check("clr_alu_f", 32'(af[d]), 32'd0);
      check("clr_rsp_y", ry[d], 32'd0);
      check("clr_rsp_zero", 32'(rz[d]), 32'd0);
      check("clr_rsp_err", 32'(re[d]), 32'd0);
      check("clr_rsp_valid", 32'({sv[d][0], sv[d][1]}), 32'd0);
      check("clr_req_ready", 32'({rr[d][0], rr[d][1]}), 32'd0);
      check("clr_ops_done", get_od(d), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      q.delete();
      exp_ops[0] = 0;
      exp_ops[1] = 0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 2; r++) begin
            rv[d][r]   = 1'b0;
            ra[d][r]   = '0;
            rb[d][r]   = '0;
            rf[d][r]   = '0;
            srdy[d][r] = 1'b0;
         end
      end
      do_reset();
      check_cleared(0);
      check_cleared(1);

      // Single add on requester 0.
      present(0, 0, 32'd5, 32'd7, 3'b010);
      issue(0, 0, w);
      check("single_add_no_wait", 32'(w), 32'd0);
      collect(0, 0, 2, 0);

      // Contention from a fresh reset: 0, 1, then 0, 1 again.
      do_reset();
      present(0, 0, 32'd3, 32'd3, 3'b110);
      present(0, 1, 32'hFFFF_FFFF, 32'd4, 3'b111);
      issue(0, 0, w);
      collect(0, 0, 2, 0);
      issue(0, 1, w);
      collect(0, 1, 2, 0);
      present(0, 0, 32'd10, 32'd3, 3'b100);
      present(0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 3'b010);
      issue(0, 0, w);
      collect(0, 0, 2, 0);
      issue(0, 1, w);
      collect(0, 1, 2, 0);

      // Backpressure on requester 1 with requester 0 waiting.
      present(0, 1, 32'd100, 32'd58, 3'b110);
      issue(0, 1, w);
      present(0, 0, 32'd1, 32'd2, 3'b010);
      collect(0, 1, 2, 5);
      check("req0_ready_after_handshake", 32'(rr[0][0]), 32'd1);
      issue(0, 0, w);
      check("req0_granted_at_once", 32'(w), 32'd0);
      collect(0, 0, 2, 0);

      // Illegal codes answer straight away with an error.
      present(0, 1, 32'd9, 32'd9, 3'b101);
      issue(0, 1, w);
      collect(0, 1, 0, 0);
      present(0, 0, 32'd4, 32'd4, 3'b000);
      issue(0, 0, w);
      collect(0, 0, 0, 0);

      // Reset in the middle of a wait drops the operation.
      present(0, 0, 32'h0000_F0F0, 32'h0000_0FF0, 3'b011);
      issue(0, 0, w);
      tick();
      #2;
      reset = 1'b1;
      #1;
      check_cleared(0);
      q.delete();
      exp_ops[0] = 0;
      exp_ops[1] = 0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("no_rsp_after_reset", 32'({sv[0][0], sv[0][1]}), 32'd0);
      end
      present(0, 0, 32'h0000_F0F0, 32'h0000_0FF0, 3'b011);
      present(0, 1, 32'd6, 32'd2, 3'b110);
      issue(0, 0, w);
      collect(0, 0, 2, 0);
      issue(0, 1, w);
      collect(0, 1, 2, 0);

      // Longer latency and a 2-bit saturating counter.
      for (int i = 0; i < 5; i++) begin
         present(1, i % 2, 32'(i * 3), 32'd3, (i == 2) ? 3'b110 : 3'b010);
         issue(1, i % 2, w);
         collect(1, i % 2, 4, 0);
      end
      check("sat_ops_done", get_od(1), 32'd3);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
